axis_pkt_arbiter: RTL and testbench
===================================

Name: axis_pkt_arbiter

Overview:
Packet-level round-robin arbiter that drives the 3-bit source select of the 5-way AXI-Stream mux. The five sources are master1, master2, slave1, slave2 and slave3.
- Sits between the mux output and the downstream sink.
- Gates tvalid and tready so that only the granted source can handshake.
- Holds the grant until the tlast beat completes.
- Releases a stalled source after a programmable timeout and flags an error.

Parameters:
- TIMEOUT_CYCLES, 256: number of consecutive no-handshake cycles in XFER before the grant is aborted. 0 disables the timeout.
- CNT_W, 16: width of the stall counter. Must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tvalid_m1, tvalid_m2, tvalid_s1, tvalid_s2, tvalid_s3  in  1 each  per-source request: the raw tvalid of each source.
- mux_tvalid  in  1  tvalid at the mux output, i.e. of the selected source.
- mux_tlast  in  1  tlast at the mux output.
- mux_tready  out  1  tready driven into the mux; the mux routes it to the selected source.
- sink_tvalid  out  1  gated tvalid to the sink.
- sink_tready  in  1  sink tready.
- sel  out  3  mux select. 1=master1, 2=master2, 3=slave1, 4=slave2, 5=slave3. 0 means no grant.
- busy  out  1  high while a grant is held (XFER state).
- timeout_err  out  1  one-cycle pulse when a grant is aborted by timeout.
- timeout_sel  out  3  sel value of the source most recently aborted; holds its value until the next abort.

Behaviour:
- Reset: all outputs go to 0 and the state goes to IDLE. The round-robin pointer goes to last=5, so master1 has the highest priority first. The stall counter goes to 0.
- Reset mid-packet: the grant drops at the next edge with no tlast required. The source's packet is truncated, and this is the source's concern.
- Gating is combinational from registered state:
  - sink_tvalid = mux_tvalid & busy.
  - mux_tready = sink_tready & busy.
  - A handshake (hs) is sink_tvalid & sink_tready.
- sel, busy, timeout_err and timeout_sel are registered.
- The arbiter implements the FSM below.
- State IDLE:
  - busy=0, sel=0.
  - If any tvalid_x is high, pick the first requester after the last-winner pointer in the cyclic order 1,2,3,4,5.
  - Register sel=winner and busy=1, and go to XFER.
  - Otherwise stay in IDLE.
  - Only requests sampled in this cycle count.
- State XFER:
  - sel is frozen regardless of the tvalid_x inputs.
  - On hs with mux_tlast=1: set the pointer to sel, then next cycle sel=0, busy=0, go to IDLE.
  - On hs with mux_tlast=0: stay in XFER and clear the counter.
  - With no hs: increment the counter.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with no hs: the next cycle goes to IDLE with sel=0 and busy=0, pulses timeout_err, and loads timeout_sel with the old sel. The pointer is also set to the old sel, so the stuck source loses priority.
  - hs in the same cycle as the timeout threshold: the handshake wins and there is no abort.
- Latency:
  - Request in IDLE at cycle N → sel valid and gate open at N+1. The first beat can complete at N+1.
  - After a tlast handshake at cycle M: IDLE at M+1, next grant at M+2. There is one mandatory bubble cycle between packets.
- Fairness: with all five requesting continuously, grants rotate 1,2,3,4,5,1,…
- Single-beat packets (tlast on the first beat) are legal.
- A source that drops tvalid mid-packet keeps the grant until tlast or timeout.
- The counter saturates and never wraps.

Test Plan:
- Reset, then assert tvalid_s2 with a 3-beat packet and sink_tready=1. Required: sel=4 one cycle after the request, 3 sink handshakes, busy drops the cycle after the tlast beat, then sel=0.
- All 5 requesters hold 1-beat packets continuously. Required: the sel sequence is 1,2,3,4,5,1 with exactly one sel=0 bubble between grants.
- master1 is mid-packet and slave3 asserts tvalid. Required: sel stays 1 until master1's tlast handshake, then sel=5 two cycles later.
- sink_tready=0 for 10 cycles in the middle of a packet with TIMEOUT_CYCLES=256. Required: no abort, mux_tready=0 throughout, and the packet completes intact afterwards.
- TIMEOUT_CYCLES=8, master2 granted, then tvalid_m2 drops permanently after beat 1. Required: 8 stall cycles, then timeout_err pulses for 1 cycle, timeout_sel=2, and the next grant goes to a later source ahead of master2.
- Assert rst for 1 cycle during a master1 packet. Required: sel=0, busy=0 and sink_tvalid=0 on the next cycle, and the next grant order restarts at master1.

Source files
------------

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter
// Packet-level round-robin arbiter for a 5-way AXI-Stream mux.
// Sits between the mux output and the downstream sink. Only the granted source
// can handshake. The grant is held until the tlast beat completes, or until a
// stall timeout aborts it.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   tvalid_m1..s3      raw tvalid of each source (requests)
//   mux_tvalid/tlast   tvalid/tlast at the mux output (selected source)
//   mux_tready         tready into the mux (gated sink_tready)
//   sink_tvalid        gated tvalid to the sink
//   sink_tready        sink tready
//   sel                mux select: 1=m1 2=m2 3=s1 4=s2 5=s3, 0=no grant
//   busy               grant held (XFER state); this is also the FSM state view
//   timeout_err        one-cycle pulse when a grant is aborted
//   timeout_sel        sel of the most recently aborted source
//
// Handshake: a beat transfers on a cycle where sink_tvalid and sink_tready are
// both high. tvalid/tready are only gated here; the payload is never held, and
// a source must keep tvalid and its data stable until the beat transfers.
module axis_pkt_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tvalid_m1,
  input  logic       tvalid_m2,
  input  logic       tvalid_s1,
  input  logic       tvalid_s2,
  input  logic       tvalid_s3,
  input  logic       mux_tvalid,
  input  logic       mux_tlast,
  output logic       mux_tready,
  output logic       sink_tvalid,
  input  logic       sink_tready,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout_err,
  output logic [2:0] timeout_sel
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state;
  logic [2:0]       last_q;   // sel of the last winner (1..5)
  logic [CNT_W-1:0] cnt;      // consecutive no-handshake cycles in XFER
  logic [4:0]       req;
  logic [2:0]       winner;
  logic [3:0]       cand;
  logic             hs;
  logic             timeout_hit;

  assign req = {tvalid_s3, tvalid_s2, tvalid_s1, tvalid_m2, tvalid_m1};

  // Gating uses only registered busy so the sink path is a single AND gate.
  assign sink_tvalid = mux_tvalid & busy;
  assign mux_tready  = sink_tready & busy;
  assign hs          = sink_tvalid & sink_tready;

  // Abort on the TIMEOUT_CYCLES-th consecutive stalled cycle. A handshake on
  // that same cycle takes priority because hs is tested first in the FSM.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Round-robin pick: walk candidates last+5 down to last+1 (wrapped to 1..5)
  // so the nearest requester after the pointer is written last and wins.
  always_comb begin
    winner = 3'd0;
    cand   = 4'd0;
    for (int i = 5; i >= 1; i--) begin
      cand = {1'b0, last_q} + 4'(i);
      if (cand > 4'd5) cand = cand - 4'd5;
      if (req[3'(cand - 4'd1)]) winner = cand[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= 3'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      timeout_sel <= 3'd0;
      last_q      <= 3'd5;
      cnt         <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (winner != 3'd0) begin
            state <= XFER;
            sel   <= winner;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        XFER: begin
          if (hs) begin
            cnt <= '0;
            if (mux_tlast) begin
              state  <= IDLE;
              sel    <= 3'd0;
              busy   <= 1'b0;
              last_q <= sel;
            end
          end else if (timeout_hit) begin
            // The stuck source becomes the pointer so it loses priority.
            state       <= IDLE;
            sel         <= 3'd0;
            busy        <= 1'b0;
            last_q      <= sel;
            timeout_err <= 1'b1;
            timeout_sel <= sel;
            cnt         <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;   // saturate, never wrap
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
module tb_axis_pkt_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] tv  = 5'd0;   // {s3, s2, s1, m2, m1}
  logic       mux_tvalid = 1'b0;
  logic       mux_tlast  = 1'b0;
  logic       sink_tready = 1'b0;

  // DUT with default timeout
  logic       a_mux_tready, a_sink_tvalid, a_busy, a_terr;
  logic [2:0] a_sel, a_tsel;
  // DUT with short timeout
  logic       b_mux_tready, b_sink_tvalid, b_busy, b_terr;
  logic [2:0] b_sel, b_tsel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_pkt_arbiter #(.TIMEOUT_CYCLES(256), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .tvalid_m1(tv[0]), .tvalid_m2(tv[1]), .tvalid_s1(tv[2]),
    .tvalid_s2(tv[3]), .tvalid_s3(tv[4]),
    .mux_tvalid(mux_tvalid), .mux_tlast(mux_tlast),
    .mux_tready(a_mux_tready), .sink_tvalid(a_sink_tvalid),
    .sink_tready(sink_tready), .sel(a_sel), .busy(a_busy),
    .timeout_err(a_terr), .timeout_sel(a_tsel)
  );

  axis_pkt_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst),
    .tvalid_m1(tv[0]), .tvalid_m2(tv[1]), .tvalid_s1(tv[2]),
    .tvalid_s2(tv[3]), .tvalid_s3(tv[4]),
    .mux_tvalid(mux_tvalid), .mux_tlast(mux_tlast),
    .mux_tready(b_mux_tready), .sink_tvalid(b_sink_tvalid),
    .sink_tready(sink_tready), .sel(b_sel), .busy(b_busy),
    .timeout_err(b_terr), .timeout_sel(b_tsel)
  );

  // One row = inputs driven for a cycle + outputs required in that cycle
  // (registered outputs reflect all earlier edges; gated outputs reflect
  // this row's inputs).
  typedef struct {
    logic       rst;
    logic [4:0] tv;
    logic       mv;
    logic       ml;
    logic       tr;
    logic [2:0] e_sel;
    logic       e_busy;
    logic       e_stv;
    logic       e_mtr;
    logic       e_terr;
    logic [2:0] e_tsel;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [4:0] t, input logic mv,
                     input logic ml, input logic tr, input logic [2:0] es,
                     input logic eb, input logic estv, input logic emtr,
                     input logic eterr, input logic [2:0] etsel);
    vec_t v;
    v.rst = r; v.tv = t; v.mv = mv; v.ml = ml; v.tr = tr;
    v.e_sel = es; v.e_busy = eb; v.e_stv = estv; v.e_mtr = emtr;
    v.e_terr = eterr; v.e_tsel = etsel;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tv = 5'd0; mux_tvalid = 1'b0; mux_tlast = 1'b0;
    sink_tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tbl.delete();
  endtask

  task automatic run_table(input string nm, input bit use_b);
    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      rst = tbl[r].rst; tv = tbl[r].tv; mux_tvalid = tbl[r].mv;
      mux_tlast = tbl[r].ml; sink_tready = tbl[r].tr;
      #1;
      chk({nm, ".sel"},  r, {5'd0, use_b ? b_sel  : a_sel},  {5'd0, tbl[r].e_sel});
      chk({nm, ".busy"}, r, {7'd0, use_b ? b_busy : a_busy}, {7'd0, tbl[r].e_busy});
      chk({nm, ".sink_tvalid"}, r, {7'd0, use_b ? b_sink_tvalid : a_sink_tvalid},
          {7'd0, tbl[r].e_stv});
      chk({nm, ".mux_tready"}, r, {7'd0, use_b ? b_mux_tready : a_mux_tready},
          {7'd0, tbl[r].e_mtr});
      chk({nm, ".timeout_err"}, r, {7'd0, use_b ? b_terr : a_terr},
          {7'd0, tbl[r].e_terr});
      chk({nm, ".timeout_sel"}, r, {5'd0, use_b ? b_tsel : a_tsel},
          {5'd0, tbl[r].e_tsel});
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    #1;
    chk("reset.a_sel", 0, {5'd0, a_sel}, 8'd0);
    chk("reset.a_busy", 0, {7'd0, a_busy}, 8'd0);
    chk("reset.a_terr", 0, {7'd0, a_terr}, 8'd0);
    chk("reset.a_tsel", 0, {5'd0, a_tsel}, 8'd0);
    chk("reset.b_sel", 0, {5'd0, b_sel}, 8'd0);
    chk("reset.b_tsel", 0, {5'd0, b_tsel}, 8'd0);

    // slave2, 3-beat packet
    do_reset();
    add(0, 5'b01000, 0, 0, 1, 3'd0, 0, 0, 0, 0, 3'd0);
    add(0, 5'b01000, 1, 0, 1, 3'd4, 1, 1, 1, 0, 3'd0);
    add(0, 5'b01000, 1, 0, 1, 3'd4, 1, 1, 1, 0, 3'd0);
    add(0, 5'b01000, 1, 1, 1, 3'd4, 1, 1, 1, 0, 3'd0);
    add(0, 5'b00000, 0, 0, 1, 3'd0, 0, 0, 0, 0, 3'd0);
    run_table("s2_pkt", 1'b0);

    // all five requesting single-beat packets: 1,2,3,4,5,1 with bubbles
    do_reset();
    for (int k = 0; k < 6; k++) begin
      add(0, 5'b11111, 1, 1, 1, 3'd0, 0, 0, 0, 0, 3'd0);
      add(0, 5'b11111, 1, 1, 1, 3'(k % 5 + 1), 1, 1, 1, 0, 3'd0);
    end
    run_table("rr", 1'b0);

    // master1 mid-packet, slave3 waits, granted two cycles after tlast
    do_reset();
    add(0, 5'b00001, 0, 0, 1, 3'd0, 0, 0, 0, 0, 3'd0);
    add(0, 5'b10001, 1, 0, 1, 3'd1, 1, 1, 1, 0, 3'd0);
    add(0, 5'b10001, 1, 0, 1, 3'd1, 1, 1, 1, 0, 3'd0);
    add(0, 5'b10001, 1, 1, 1, 3'd1, 1, 1, 1, 0, 3'd0);
    add(0, 5'b10000, 0, 0, 1, 3'd0, 0, 0, 0, 0, 3'd0);
    add(0, 5'b10000, 1, 1, 1, 3'd5, 1, 1, 1, 0, 3'd0);
    add(0, 5'b00000, 0, 0, 1, 3'd0, 0, 0, 0, 0, 3'd0);
    run_table("hold", 1'b0);

    // 10-cycle sink stall, no abort with the long timeout
    do_reset();
    add(0, 5'b00001, 0, 0, 1, 3'd0, 0, 0, 0, 0, 3'd0);
    add(0, 5'b00001, 1, 0, 1, 3'd1, 1, 1, 1, 0, 3'd0);
    for (int k = 0; k < 10; k++)
      add(0, 5'b00001, 1, 0, 0, 3'd1, 1, 1, 0, 0, 3'd0);
    add(0, 5'b00001, 1, 0, 1, 3'd1, 1, 1, 1, 0, 3'd0);
    add(0, 5'b00001, 1, 1, 1, 3'd1, 1, 1, 1, 0, 3'd0);
    add(0, 5'b00000, 0, 0, 1, 3'd0, 0, 0, 0, 0, 3'd0);
    run_table("stall", 1'b0);

    // timeout of 8: master2 drops tvalid after beat 1
    do_reset();
    add(0, 5'b00010, 0, 0, 1, 3'd0, 0, 0, 0, 0, 3'd0);
    add(0, 5'b00010, 1, 0, 1, 3'd2, 1, 1, 1, 0, 3'd0);
    for (int k = 0; k < 8; k++)
      add(0, 5'b00101, 0, 0, 1, 3'd2, 1, 0, 1, 0, 3'd0);
    add(0, 5'b00101, 0, 0, 1, 3'd0, 0, 0, 0, 1, 3'd2);
    add(0, 5'b00101, 1, 1, 1, 3'd3, 1, 1, 1, 0, 3'd2);
    add(0, 5'b00000, 0, 0, 1, 3'd0, 0, 0, 0, 0, 3'd2);
    run_table("timeout", 1'b1);

    // reset mid-packet, order restarts at master1
    do_reset();
    add(0, 5'b00011, 0, 0, 1, 3'd0, 0, 0, 0, 0, 3'd0);
    add(0, 5'b00011, 1, 0, 1, 3'd1, 1, 1, 1, 0, 3'd0);
    add(1, 5'b00011, 1, 0, 1, 3'd1, 1, 1, 1, 0, 3'd0);
    add(0, 5'b00011, 1, 0, 1, 3'd0, 0, 0, 0, 0, 3'd0);
    add(0, 5'b00011, 1, 1, 1, 3'd1, 1, 1, 1, 0, 3'd0);
    add(0, 5'b00010, 0, 0, 1, 3'd0, 0, 0, 0, 0, 3'd0);
    add(0, 5'b00010, 1, 1, 1, 3'd2, 1, 1, 1, 0, 3'd0);
    add(0, 5'b00000, 0, 0, 1, 3'd0, 0, 0, 0, 0, 3'd0);
    run_table("midrst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
